// File: rtl/control_unit_if.sv
// Control bundle between the control unit and the single-bus datapath.
// master = control unit side, slave = datapath side.
interface control_unit_if;
    logic [31:0] IR_Data;
    logic        con_output;
    logic        PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable;
    logic        MAR_enable, MDR_enable, HI_enable, LO_enable;
    logic        read, write;
    logic        Gra, Grb, Grc, r_enable, r_select, BAout;
    logic        PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select;
    logic        InPort_select, c_select;
    logic [4:0]  alu_instruction;
    logic        run;
    logic [3:0]  t_state;

    modport master (
        input  IR_Data, con_output,
        output PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, HI_enable, LO_enable, read, write,
               Gra, Grb, Grc, r_enable, r_select, BAout,
               PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select,
               InPort_select, c_select, alu_instruction, run, t_state
    );

    modport slave (
        output IR_Data, con_output,
        input  PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable,
               MAR_enable, MDR_enable, HI_enable, LO_enable, read, write,
               Gra, Grb, Grc, r_enable, r_select, BAout,
               PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select,
               InPort_select, c_select, alu_instruction, run, t_state
    );
endinterface

// File: rtl/control_unit.sv
// Moore fetch/decode/execute sequencer for the single-bus CPU.
// CTRL_SINGLE_STEP_EN adds a step input and a PAUSE state after every instruction.
module control_unit #(
    parameter int         MEM_WAIT = 1,
    parameter logic [4:0] ALU_ADD  = 5'b00011
) (
    input  logic           clk,
    input  logic           clr,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic           step,
`endif
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_PAUSE
    } state_t;

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t S_DONE = S_PAUSE;
`else
    localparam state_t S_DONE = S_T0;
`endif

    localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_BR = 5'b10010;
    localparam logic [4:0] OP_JR = 5'b10011, OP_IN = 5'b10101, OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000, OP_HALT = 5'b11010;
    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    typedef struct packed {
        logic pc_en, pc_inc, ir_en, con_en, y_en, z_en, mar_en, mdr_en, hi_en, lo_en;
        logic rd, wr, gra, grb, grc, r_en, r_sel, ba_out;
        logic pc_sel, hi_sel, lo_sel, zhi_sel, zlo_sel, mdr_sel, in_sel, c_sel;
        logic [4:0] alu;
    } ctl_t;

    state_t        state, state_nxt;
    ctl_t          c;
    logic [CW-1:0] wait_cnt;
    logic          mem_done;
    logic [4:0]    op;
    logic          is_rr, is_imm, is_alu, is_ld, is_ldi, is_st, is_mem, is_md, is_br;

    assign op       = bus.IR_Data[31:27];
    assign is_rr    = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_imm   = (op >= 5'b01100) && (op <= 5'b01110);
    assign is_alu   = is_rr | is_imm;
    assign is_ld    = (op == OP_LD);
    assign is_ldi   = (op == OP_LDI);
    assign is_st    = (op == OP_ST);
    assign is_mem   = is_ld | is_ldi | is_st;
    assign is_md    = (op == OP_MUL) || (op == OP_DIV);
    assign is_br    = (op == OP_BR);
    assign mem_done = (wait_cnt == '0);

    // The wait counter reloads on every state change, so each memory step starts a fresh count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_RST;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state != state_nxt) wait_cnt <= CW'(MEM_WAIT - 1);
            else if (!mem_done)     wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_comb begin
        c         = '0;
        state_nxt = state;
        case (state)
            S_RST: state_nxt = S_T0;
            S_T0: begin
                c.pc_sel = 1'b1; c.mar_en = 1'b1; c.pc_inc = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                c.rd = 1'b1; c.mdr_en = 1'b1;
                if (mem_done) state_nxt = S_T2;
            end
            S_T2: begin
                c.mdr_sel = 1'b1; c.ir_en = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                state_nxt = S_T4;
                if (is_alu) begin
                    c.grb = 1'b1; c.r_sel = 1'b1; c.y_en = 1'b1;
                end else if (is_mem) begin
                    c.grb = 1'b1; c.r_sel = 1'b1; c.ba_out = 1'b1; c.y_en = 1'b1;
                end else if (is_md) begin
                    c.gra = 1'b1; c.r_sel = 1'b1; c.y_en = 1'b1;
                end else if (is_br) begin
                    c.gra = 1'b1; c.r_sel = 1'b1; c.con_en = 1'b1;
                end else begin
                    state_nxt = S_DONE;
                    case (op)
                        OP_JR:   begin c.gra = 1'b1; c.r_sel = 1'b1; c.pc_en = 1'b1; end
                        OP_MFHI: begin c.hi_sel = 1'b1; c.gra = 1'b1; c.r_en = 1'b1; end
                        OP_MFLO: begin c.lo_sel = 1'b1; c.gra = 1'b1; c.r_en = 1'b1; end
                        OP_IN:   begin c.in_sel = 1'b1; c.gra = 1'b1; c.r_en = 1'b1; end
                        OP_HALT: state_nxt = S_HALT;
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                state_nxt = S_T5;
                if (is_br) begin
                    c.pc_sel = 1'b1; c.y_en = 1'b1;
                end else begin
                    c.z_en = 1'b1; c.alu = op;
                    if (is_rr)      begin c.grc = 1'b1; c.r_sel = 1'b1; end
                    else if (is_md) begin c.grb = 1'b1; c.r_sel = 1'b1; end
                    else begin
                        c.c_sel = 1'b1;
                        if (is_mem) c.alu = ALU_ADD;
                    end
                end
            end
            S_T5: begin
                state_nxt = S_T6;
                if (is_br) begin
                    c.c_sel = 1'b1; c.z_en = 1'b1; c.alu = ALU_ADD;
                end else begin
                    c.zlo_sel = 1'b1;
                    if (is_md)              c.lo_en = 1'b1;
                    else if (is_ld | is_st) c.mar_en = 1'b1;
                    else begin
                        c.gra = 1'b1; c.r_en = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_T6: begin
                state_nxt = S_DONE;
                if (is_ld) begin
                    c.rd = 1'b1; c.mdr_en = 1'b1;
                    state_nxt = mem_done ? S_T7 : S_T6;
                end else if (is_st) begin
                    c.gra = 1'b1; c.r_sel = 1'b1; c.mdr_en = 1'b1;
                    state_nxt = S_T7;
                end else if (is_md) begin
                    c.zhi_sel = 1'b1; c.hi_en = 1'b1;
                end else if (is_br && bus.con_output) begin
                    c.zlo_sel = 1'b1; c.pc_en = 1'b1;
                end
            end
            S_T7: begin
                state_nxt = S_DONE;
                if (is_st) begin
                    c.wr = 1'b1;
                    if (!mem_done) state_nxt = S_T7;
                end else begin
                    c.mdr_sel = 1'b1; c.gra = 1'b1; c.r_en = 1'b1;
                end
            end
            S_HALT: ;
            S_PAUSE: begin
`ifdef CTRL_SINGLE_STEP_EN
                if (step) state_nxt = S_T0;
`else
                state_nxt = S_T0;
`endif
            end
            default: state_nxt = S_RST;
        endcase
    end

    // T0..T7 are encoded consecutively, so the step number is an offset from S_T0.
    assign bus.run     = (state >= S_T0) && (state <= S_T7);
    assign bus.t_state = bus.run ? (4'(state) - 4'(S_T0)) : 4'd0;

    assign bus.PC_enable           = c.pc_en;
    assign bus.PC_increment_enable = c.pc_inc;
    assign bus.IR_enable           = c.ir_en;
    assign bus.con_enable          = c.con_en;
    assign bus.Y_enable            = c.y_en;
    assign bus.Z_enable            = c.z_en;
    assign bus.MAR_enable          = c.mar_en;
    assign bus.MDR_enable          = c.mdr_en;
    assign bus.HI_enable           = c.hi_en;
    assign bus.LO_enable           = c.lo_en;
    assign bus.read                = c.rd;
    assign bus.write               = c.wr;
    assign bus.Gra                 = c.gra;
    assign bus.Grb                 = c.grb;
    assign bus.Grc                 = c.grc;
    assign bus.r_enable            = c.r_en;
    assign bus.r_select            = c.r_sel;
    assign bus.BAout               = c.ba_out;
    assign bus.PC_select           = c.pc_sel;
    assign bus.HI_select           = c.hi_sel;
    assign bus.LO_select           = c.lo_sel;
    assign bus.Z_HI_select         = c.zhi_sel;
    assign bus.Z_LO_select         = c.zlo_sel;
    assign bus.MDR_select          = c.mdr_sel;
    assign bus.InPort_select       = c.in_sel;
    assign bus.c_select            = c.c_sel;
    assign bus.alu_instruction     = c.alu;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected control-word lists built from the step table,
// compared cycle by cycle against the DUT outputs.
module tb_control_unit;
    localparam int MW = 3;

    logic clk = 1'b0;
    logic clr;
    logic step;
    int   checks = 0;
    int   errors = 0;

    control_unit_if bus ();

    control_unit #(.MEM_WAIT(MW), .ALU_ADD(5'b00011)) dut (
        .clk (clk),
        .clr (clr),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Word layout: [35:32] step, [31:27] alu, [26] run, [25:0] strobes/selects.
    localparam logic [25:0] PCE = 26'd1 << 0,  PCI = 26'd1 << 1,  IRE = 26'd1 << 2,  CONE = 26'd1 << 3;
    localparam logic [25:0] YE = 26'd1 << 4,   ZE = 26'd1 << 5,   MARE = 26'd1 << 6, MDRE = 26'd1 << 7;
    localparam logic [25:0] HIE = 26'd1 << 8,  LOE = 26'd1 << 9,  RD = 26'd1 << 10,  WR = 26'd1 << 11;
    localparam logic [25:0] GRA = 26'd1 << 12, GRB = 26'd1 << 13, GRC = 26'd1 << 14, RE = 26'd1 << 15;
    localparam logic [25:0] RSEL = 26'd1 << 16, BA = 26'd1 << 17, PCS = 26'd1 << 18, HIS = 26'd1 << 19;
    localparam logic [25:0] LOS = 26'd1 << 20, ZHS = 26'd1 << 21, ZLS = 26'd1 << 22, MDRS = 26'd1 << 23;
    localparam logic [25:0] INS = 26'd1 << 24, CS = 26'd1 << 25;
    localparam logic [4:0]  ADD = 5'b00011;

    logic [35:0] dut_w;
    assign dut_w = {bus.t_state, bus.alu_instruction, bus.run, bus.c_select, bus.InPort_select,
                    bus.MDR_select, bus.Z_LO_select, bus.Z_HI_select, bus.LO_select, bus.HI_select,
                    bus.PC_select, bus.BAout, bus.r_select, bus.r_enable, bus.Grc, bus.Grb, bus.Gra,
                    bus.write, bus.read, bus.LO_enable, bus.HI_enable, bus.MDR_enable, bus.MAR_enable,
                    bus.Z_enable, bus.Y_enable, bus.con_enable, bus.IR_enable,
                    bus.PC_increment_enable, bus.PC_enable};

    logic [35:0] exp_q[$];

    function automatic logic [35:0] w(input int t, input logic [25:0] m, input logic [4:0] alu);
        return {4'(t), alu, 1'b1, m};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected cycle sequence for one instruction, starting at T0.
    task automatic push_instr(input logic [4:0] op, input logic con);
        exp_q.push_back(w(0, PCS | MARE | PCI, 5'd0));
        repeat (MW) exp_q.push_back(w(1, RD | MDRE, 5'd0));
        exp_q.push_back(w(2, MDRS | IRE, 5'd0));
        if (op >= 5'd3 && op <= 5'd14) begin
            exp_q.push_back(w(3, GRB | RSEL | YE, 5'd0));
            exp_q.push_back(w(4, ((op <= 5'd11) ? (GRC | RSEL) : CS) | ZE, op));
            exp_q.push_back(w(5, ZLS | GRA | RE, 5'd0));
        end else if (op <= 5'd2) begin
            exp_q.push_back(w(3, GRB | RSEL | BA | YE, 5'd0));
            exp_q.push_back(w(4, CS | ZE, ADD));
            if (op == 5'd1) exp_q.push_back(w(5, ZLS | GRA | RE, 5'd0));
            else begin
                exp_q.push_back(w(5, ZLS | MARE, 5'd0));
                if (op == 5'd0) begin
                    repeat (MW) exp_q.push_back(w(6, RD | MDRE, 5'd0));
                    exp_q.push_back(w(7, MDRS | GRA | RE, 5'd0));
                end else begin
                    exp_q.push_back(w(6, GRA | RSEL | MDRE, 5'd0));
                    repeat (MW) exp_q.push_back(w(7, WR, 5'd0));
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(w(3, GRA | RSEL | YE, 5'd0));
            exp_q.push_back(w(4, GRB | RSEL | ZE, op));
            exp_q.push_back(w(5, ZLS | LOE, 5'd0));
            exp_q.push_back(w(6, ZHS | HIE, 5'd0));
        end else if (op == 5'd18) begin
            exp_q.push_back(w(3, GRA | RSEL | CONE, 5'd0));
            exp_q.push_back(w(4, PCS | YE, 5'd0));
            exp_q.push_back(w(5, CS | ZE, ADD));
            exp_q.push_back(w(6, con ? (ZLS | PCE) : 26'd0, 5'd0));
        end else if (op == 5'd19) exp_q.push_back(w(3, GRA | RSEL | PCE, 5'd0));
        else if (op == 5'd23)     exp_q.push_back(w(3, HIS | GRA | RE, 5'd0));
        else if (op == 5'd24)     exp_q.push_back(w(3, LOS | GRA | RE, 5'd0));
        else if (op == 5'd21)     exp_q.push_back(w(3, INS | GRA | RE, 5'd0));
        else                      exp_q.push_back(w(3, 26'd0, 5'd0));
`ifdef CTRL_SINGLE_STEP_EN
        if (op != 5'd26) exp_q.push_back(36'd0);
`endif
    endtask

    task automatic drain(input string tag);
        logic [35:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, dut_w, e);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_ir(input logic [31:0] ir, input logic con, input string tag);
        bus.IR_Data    = ir;
        bus.con_output = con;
        push_instr(ir[31:27], con);
        drain(tag);
    endtask

    initial begin
        logic [4:0] op;
        clr = 1'b0; step = 1'b1;
        bus.IR_Data = '0; bus.con_output = 1'b0;
        #12;
        chk("reset", dut_w, 36'd0);
        clr = 1'b1;
        @(posedge clk); #1;

        run_ir(32'h18918000, 1'b0, "add");
        run_ir({5'd0, 27'($urandom)}, 1'b0, "ld");
        run_ir({5'd1, 27'($urandom)}, 1'b0, "ldi");
        run_ir({5'd2, 27'($urandom)}, 1'b0, "st");
        run_ir({5'd18, 27'($urandom)}, 1'b1, "br_taken");
        run_ir({5'd18, 27'($urandom)}, 1'b0, "br_not_taken");
        run_ir({5'd15, 27'($urandom)}, 1'b0, "mul");

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd26) op = 5'd25;
            run_ir({op, 27'($urandom)}, 1'($urandom), "random");
        end

        // Abort in the middle of a memory read.
        bus.IR_Data = {5'd0, 27'd0};
        exp_q.push_back(w(0, PCS | MARE | PCI, 5'd0));
        exp_q.push_back(w(1, RD | MDRE, 5'd0));
        drain("pre_abort");
        chk("t1_read", dut_w, w(1, RD | MDRE, 5'd0));
        #2 clr = 1'b0;
        #1 chk("clr_abort", dut_w, 36'd0);
        #2 clr = 1'b1;
        @(posedge clk); #1;
        run_ir({5'd3, 27'($urandom)}, 1'b0, "post_abort");

`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
        run_ir({5'd31, 27'd0}, 1'b0, "nop_pause");
        repeat (5) begin
            chk("pause_hold", dut_w, 36'd0);
            @(posedge clk); #1;
        end
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        run_ir({5'd31, 27'd0}, 1'b0, "single_step");
        repeat (3) begin
            chk("pause_after_step", dut_w, 36'd0);
            @(posedge clk); #1;
        end
        step = 1'b1;
        @(posedge clk); #1;
`endif

        run_ir({5'd26, 27'($urandom)}, 1'b0, "halt_fetch");
        repeat (100) begin
            chk("halt_idle", dut_w, 36'd0);
            @(posedge clk); #1;
        end
        clr = 1'b0;
        #2 clr = 1'b1;
        @(posedge clk); #1;
        run_ir({5'd24, 27'($urandom)}, 1'b0, "resume");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
